// File: rtl/sound_mixer.sv
//============================================================================
// Module : sound_mixer
// Purpose: Time-multiplexed audio mixer. Applies per-channel volume and mute,
//          then a master volume, to NUM_CH signed 16-bit channel samples. The
//          result is summed, saturated and presented as one signed 16-bit
//          mix per sample tick. A single multiplier serves every channel, with
//          one multiply-accumulate per clock.
//
// Optional feature macro: SOUND_MIXER_DC_BLOCK_EN
//   When this macro is defined, a DC-blocking filter stage (DCF) follows the
//   saturation stage, and latency grows by one cycle.
//
// Parameters
//   NUM_CH  number of channel inputs (1..16)
//   VOL_W   width of volume words; gain = vol / 2^VOL_W
//
// Ports
//   I_CLK         in   system clock
//   I_RSTn        in   asynchronous active-low reset
//   I_SAMPLE_STB  in   one-cycle pulse that starts a mix
//   I_SND         in   channel samples, signed, channel n at [16n+15:16n]
//   I_VOL         in   per-channel volume, unsigned
//   I_MUTE        in   per-channel mute, 1 = contributes 0
//   I_MASTER_VOL  in   master volume, unsigned
//   I_CLR_FLAGS   in   clears the O_CLIP and O_OVERRUN sticky flags
//   O_SND         out  mixed sample, held between updates
//   O_VALID       out  one-cycle pulse while O_SND carries a new sample
//   O_BUSY        out  high while a mix is in progress
//   O_CLIP        out  sticky: saturation occurred
//   O_OVERRUN     out  sticky: a strobe arrived while busy
//
// Revision: 1.0  initial release
//============================================================================
`default_nettype none

module sound_mixer #(
  parameter int NUM_CH = 8,
  parameter int VOL_W  = 8
) (
  input  logic                      I_CLK,
  input  logic                      I_RSTn,
  input  logic                      I_SAMPLE_STB,
  input  logic [NUM_CH*16-1:0]      I_SND,
  input  logic [NUM_CH*VOL_W-1:0]   I_VOL,
  input  logic [NUM_CH-1:0]         I_MUTE,
  input  logic [VOL_W-1:0]          I_MASTER_VOL,
  input  logic                      I_CLR_FLAGS,
  output logic [15:0]               O_SND,
  output logic                      O_VALID,
  output logic                      O_BUSY,
  output logic                      O_CLIP,
  output logic                      O_OVERRUN
);

  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // The sum of NUM_CH terms, each within [-32768, 32767], fits without wrap.
  localparam int ACC_W   = 16 + $clog2(NUM_CH) + 1;
  localparam int PROD_W  = 16 + VOL_W + 1;
  localparam int MPROD_W = ACC_W + VOL_W + 1;

  localparam logic [CH_W-1:0]         LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCUM  = 3'd1;
  localparam logic [2:0] S_MASTER = 3'd2;
  localparam logic [2:0] S_SAT    = 3'd3;
`ifdef SOUND_MIXER_DC_BLOCK_EN
  localparam logic [2:0] S_DCF    = 3'd4;
  localparam logic [2:0] S_OUT    = S_DCF;
`else
  localparam logic [2:0] S_OUT    = S_SAT;
`endif

  logic [2:0]                state;
  logic [CH_W-1:0]           ch;
  logic signed [ACC_W-1:0]   acc;
  logic [NUM_CH*16-1:0]      snap_snd;
  logic [NUM_CH*VOL_W-1:0]   snap_vol;
  logic [NUM_CH-1:0]         snap_mute;
  logic [VOL_W-1:0]          snap_master;
  logic [15:0]               snd_hold;
  logic                      clip_flag;
  logic                      ovr_flag;

  // Channel multiply. Volume is zero-extended so that it multiplies as a
  // non-negative signed value.
  logic signed [15:0]        snd_sel;
  logic [VOL_W-1:0]          vol_sel;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   contrib;

  assign snd_sel = $signed(snap_snd[ch*16 +: 16]);
  assign vol_sel = snap_vol[ch*VOL_W +: VOL_W];
  assign prod    = PROD_W'(snd_sel) * PROD_W'($signed({1'b0, vol_sel}));
  // Arithmetic shift rounds toward -inf. The scaled value always fits in
  // ACC_W bits.
  assign contrib = snap_mute[ch] ? '0 : ACC_W'(prod >>> VOL_W);

  // Master volume. The gain is below 1, so the magnitude never grows.
  logic signed [MPROD_W-1:0] mprod;
  logic signed [ACC_W-1:0]   master_val;

  assign mprod      = MPROD_W'(acc) * MPROD_W'($signed({1'b0, snap_master}));
  assign master_val = ACC_W'(mprod >>> VOL_W);

  // Saturation of the master-scaled accumulator.
  logic               sat_hi;
  logic               sat_lo;
  logic signed [15:0] sat_val;

  assign sat_hi  = (acc > SAT_MAX);
  assign sat_lo  = (acc < SAT_MIN);
  assign sat_val = sat_hi ? 16'sh7FFF : (sat_lo ? 16'sh8000 : acc[15:0]);

  logic [15:0] out_val;
  logic        clip_set;

`ifdef SOUND_MIXER_DC_BLOCK_EN
  // DC blocker: y = x - x_prev + y_prev - y_prev/256. The filter history
  // holds the clamped 16-bit output, so the 18-bit sum cannot overflow.
  logic signed [15:0] x_cur;
  logic signed [15:0] x_prev;
  logic signed [15:0] y_prev;
  logic signed [17:0] dc_sum;
  logic               dc_hi;
  logic               dc_lo;
  logic signed [15:0] dcf_val;

  assign dc_sum  = 18'(x_cur) - 18'(x_prev) + 18'(y_prev) - (18'(y_prev) >>> 8);
  assign dc_hi   = (dc_sum > 18'sd32767);
  assign dc_lo   = (dc_sum < -18'sd32768);
  assign dcf_val = dc_hi ? 16'sh7FFF : (dc_lo ? 16'sh8000 : dc_sum[15:0]);
  assign out_val = dcf_val;
  assign clip_set = ((state == S_SAT) && (sat_hi || sat_lo)) ||
                    ((state == S_DCF) && (dc_hi || dc_lo));
`else
  assign out_val  = sat_val;
  assign clip_set = (state == S_SAT) && (sat_hi || sat_lo);
`endif

  // A strobe counts as busy in every state except IDLE, which includes the
  // cycle in which the result is presented.
  logic ovr_set;
  assign ovr_set = I_SAMPLE_STB && (state != S_IDLE);

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state       <= S_IDLE;
      ch          <= '0;
      acc         <= '0;
      snap_snd    <= '0;
      snap_vol    <= '0;
      snap_mute   <= '0;
      snap_master <= '0;
      snd_hold    <= '0;
      clip_flag   <= 1'b0;
      ovr_flag    <= 1'b0;
`ifdef SOUND_MIXER_DC_BLOCK_EN
      x_cur       <= '0;
      x_prev      <= '0;
      y_prev      <= '0;
`endif
    end else begin
      // Set wins over a simultaneous clear.
      clip_flag <= clip_set | (clip_flag & ~I_CLR_FLAGS);
      ovr_flag  <= ovr_set  | (ovr_flag  & ~I_CLR_FLAGS);

      case (state)
        S_IDLE: begin
          if (I_SAMPLE_STB) begin
            snap_snd    <= I_SND;
            snap_vol    <= I_VOL;
            snap_mute   <= I_MUTE;
            snap_master <= I_MASTER_VOL;
            acc         <= '0;
            ch          <= '0;
            state       <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc <= acc + contrib;
          if (ch == LAST_CH) begin
            state <= S_MASTER;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        S_MASTER: begin
          acc   <= master_val;
          state <= S_SAT;
        end
        S_SAT: begin
`ifdef SOUND_MIXER_DC_BLOCK_EN
          x_cur <= sat_val;
          state <= S_DCF;
`else
          snd_hold <= sat_val;
          state    <= S_IDLE;
`endif
        end
`ifdef SOUND_MIXER_DC_BLOCK_EN
        S_DCF: begin
          snd_hold <= dcf_val;
          x_prev   <= x_cur;
          y_prev   <= dcf_val;
          state    <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // The new sample is visible during the valid cycle and held afterwards.
  assign O_SND     = (state == S_OUT) ? out_val : snd_hold;
  assign O_VALID   = (state == S_OUT);
  assign O_BUSY    = (state != S_IDLE);
  assign O_CLIP    = clip_flag;
  assign O_OVERRUN = ovr_flag;

endmodule

`default_nettype wire
